// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_unit_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_DIVU  = 2'b01,
    MD_MULT  = 2'b10,
    MD_DIV   = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage bundle between the control path and the mul/div unit.
interface muldiv_unit_if #(
  parameter int WIDTH = muldiv_unit_pkg::WIDTH_DEF
);
  import muldiv_unit_pkg::*;

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_hi;
  logic             rd_lo;
  logic [WIDTH-1:0] rdata;
  logic             busy;
  logic             done;
  logic             stall;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, rd_hi, rd_lo,
    input  rdata, busy, done, stall, div_by_zero
  );

  modport slave (
    input  start, op, a, b, rd_hi, rd_lo,
    output rdata, busy, done, stall, div_by_zero
  );

endinterface

// File: rtl/muldiv_unit_iter_core.sv
// One-bit-per-cycle shift-add multiply / restoring divide datapath.
// acc_hi/acc_lo hold {product hi, lo} when multiplying and {rem, quo} when dividing.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] nxt_hi_s,
  output logic [WIDTH-1:0] nxt_lo_s
);

  logic [WIDTH-1:0] acc_hi_r;
  logic [WIDTH-1:0] acc_lo_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shl_s;
  logic [WIDTH:0]   diff_s;

  // Value of the accumulators after one more iteration
  always_comb begin
    sum_s  = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    // Shifted remainder keeps the bit leaving acc_hi so the trial subtract is exact
    shl_s  = {acc_hi_r, acc_lo_r[WIDTH-1]};
    diff_s = shl_s - {1'b0, b_r};
    if (div_mode) begin
      if (!diff_s[WIDTH]) begin
        nxt_hi_s = diff_s[WIDTH-1:0];
        nxt_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi_s = shl_s[WIDTH-1:0];
        nxt_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi_s = sum_s[WIDTH:1];
      nxt_lo_s = {sum_s[0], acc_lo_r[WIDTH-1:1]};
    end
  end

  // Accumulator and divisor/multiplier registers
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_hi_r <= {WIDTH{1'b0}};
      acc_lo_r <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
    end else if (load) begin
      acc_hi_r <= {WIDTH{1'b0}};
      acc_lo_r <= a;
      b_r      <= b;
    end else if (step) begin
      acc_hi_r <= nxt_hi_s;
      acc_lo_r <= nxt_lo_s;
      b_r      <= b_r;
    end else begin
      acc_hi_r <= acc_hi_r;
      acc_lo_r <= acc_lo_r;
      b_r      <= b_r;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULTU/DIVU engine owning HI/LO; stalls the pipeline while busy.
// Optional signed MULT/DIV support is enabled with the MULDIV_SIGNED_EN macro.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clock,
  input  logic           reset,
  muldiv_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t    state_r;
  muldiv_state_t    state_nxt_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;
  logic             accept_s;
  logic             last_s;
  logic             stepping_s;
  logic             op_div_s;
  logic             b_zero_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [WIDTH-1:0] core_hi_s;
  logic [WIDTH-1:0] core_lo_s;
  logic [WIDTH-1:0] wb_hi_s;
  logic [WIDTH-1:0] wb_lo_s;

`ifdef MULDIV_SIGNED_EN
  logic               neg_q_s;
  logic               neg_r_s;
  logic               neg_q_r;
  logic               neg_r_r;
  logic [2*WIDTH-1:0] prod_s;
`else
  logic               unused_op_s;
  assign unused_op_s = bus.op[1];
`endif

  assign stepping_s = (state_r == MUL) || (state_r == DIV);
  assign last_s     = stepping_s && (count_r == CW'(WIDTH-1));

  // Next-state decode; a start is only taken when no op is in flight
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          accept_s    = 1'b1;
          state_nxt_s = op_div_s ? DIV : MUL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL, DIV: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand conditioning and writeback values
  always_comb begin
    op_div_s = bus.op[0];
    b_zero_s = (bus.b == {WIDTH{1'b0}});
`ifdef MULDIV_SIGNED_EN
    a_mag_s  = (bus.op[1] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag_s  = (bus.op[1] && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    // A zero divisor leaves the all-ones quotient un-negated
    neg_q_s  = bus.op[1] && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) && !(op_div_s && b_zero_s);
    neg_r_s  = bus.op[1] && bus.a[WIDTH-1];
    prod_s   = neg_q_r ? -{core_hi_s, core_lo_s} : {core_hi_s, core_lo_s};
    if (state_r == DIV) begin
      wb_hi_s = neg_r_r ? -core_hi_s : core_hi_s;
      wb_lo_s = neg_q_r ? -core_lo_s : core_lo_s;
    end else begin
      wb_hi_s = prod_s[2*WIDTH-1:WIDTH];
      wb_lo_s = prod_s[WIDTH-1:0];
    end
`else
    a_mag_s  = bus.a;
    b_mag_s  = bus.b;
    wb_hi_s  = core_hi_s;
    wb_lo_s  = core_lo_s;
`endif
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clock    (clock),
    .reset    (reset),
    .load     (accept_s),
    .step     (stepping_s),
    .div_mode (state_r == DIV),
    .a        (a_mag_s),
    .b        (b_mag_s),
    .nxt_hi_s (core_hi_s),
    .nxt_lo_s (core_lo_s)
  );

  // FSM state, iteration counter, HI/LO and status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      count_r <= {CW{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == MUL) || (state_nxt_s == DIV);
      done_r  <= (state_nxt_s == DONE);
      if (accept_s) begin
        count_r <= {CW{1'b0}};
      end else if (stepping_s) begin
        count_r <= count_r + CW'(1);
      end else begin
        count_r <= count_r;
      end
      if (last_s) begin
        hi_r <= wb_hi_s;
        lo_r <= wb_lo_s;
      end else begin
        hi_r <= hi_r;
        lo_r <= lo_r;
      end
      dbz_r <= dbz_r | (accept_s && op_div_s && b_zero_s);
    end
  end

`ifdef MULDIV_SIGNED_EN
  // Result signs captured alongside the operand magnitudes
  always_ff @(posedge clock) begin
    if (reset) begin
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (accept_s) begin
      neg_q_r <= neg_q_s;
      neg_r_r <= neg_r_s;
    end else begin
      neg_q_r <= neg_q_r;
      neg_r_r <= neg_r_r;
    end
  end
`endif

  assign bus.rdata       = bus.rd_hi ? hi_r : lo_r;
  assign bus.stall       = busy_r & (bus.start | bus.rd_hi | bus.rd_lo);
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;

endmodule
